// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes consumed by the vending FSM
// and the coin acceptor state encoding.
package vend_pkg;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    RELEASE,
    LOCKOUT
  } acc_state_t;

  // A pattern is creditable only when exactly one coin slot is active.
  function automatic logic is_coin_code(input logic [2:0] pat);
    return (pat == COIN_NICKEL) || (pat == COIN_DIME) || (pat == COIN_QUARTER);
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous sensor inputs,
// cleared by a synchronous active-high reset.
module coin_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments let both flops sample on the same edge,
  // giving two real register stages instead of one collapsed wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the synchronised sensors and issues one
// registered coin_in or coin_reject pulse per qualified insertion.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_nickel,
  input  logic       sensor_dime,
  input  logic       sensor_quarter,
  input  logic       accept_en,
  output logic [2:0] coin_in,
  output logic       coin_reject,
  output logic       busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [2:0]       s;
  acc_state_t       state_q, state_d;
  logic [2:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       coin_d;
  logic             reject_d;

  coin_sync #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sensor_quarter, sensor_dime, sensor_nickel}),
    .q   (s)
  );

  // Reset parks in RELEASE so a coin already present is waited out, not credited.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RELEASE;
      pat_q       <= COIN_NONE;
      cnt_q       <= '0;
      coin_in     <= COIN_NONE;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      coin_in     <= coin_d;
      coin_reject <= reject_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    coin_d   = COIN_NONE;
    reject_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s != COIN_NONE) begin
          pat_d   = s;
          cnt_d   = CNT_ONE;
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (s == COIN_NONE) begin
          state_d = IDLE;
        end else if (s != pat_q) begin
          pat_d = s;
          cnt_d = CNT_ONE;
        end else if (cnt_q < DEB_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          if (is_coin_code(pat_q) && accept_en) coin_d = pat_q;
          else                                  reject_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (s == COIN_NONE) begin
          cnt_d   = '0;
          state_d = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (cnt_q == LOCK_LAST) state_d = IDLE;
        else                    cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = RELEASE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed and random sensor traces
// compared cycle by cycle with a window-search reference model.
module tb_coin_acceptor;

  localparam int DEB  = 4;
  localparam int LOCK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sn = 1'b0, sd = 1'b0, sq = 1'b0;
  logic       accept_en = 1'b0;
  logic [2:0] coin_in;
  logic       coin_reject;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Index 0 is the value driven during the reset cycle, 1..n the edges after it.
  logic [2:0] raw_q[$];
  logic       acc_q[$];
  logic [4:0] exp_q[$];  // {coin_in, coin_reject, busy}
  logic [4:0] obs_q[$];

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sensor_nickel  (sn),
    .sensor_dime    (sd),
    .sensor_quarter (sq),
    .accept_en      (accept_en),
    .coin_in        (coin_in),
    .coin_reject    (coin_reject),
    .busy           (busy)
  );

  task automatic start(input logic [2:0] r0);
    raw_q = {r0};
    acc_q = {1'b1};
  endtask

  task automatic seg(input logic [2:0] v, input int len, input logic acc);
    repeat (len) begin
      raw_q.push_back(v);
      acc_q.push_back(acc);
    end
  endtask

  function automatic logic one_hot(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  // Model: release waits for a zero sample, lockout lasts LOCK edges, then a
  // coin qualifies at the first window of DEB identical nonzero samples.
  task automatic build_model();
    int         n;
    int         t, k, j, q, idle_at, last;
    bit         ok;
    logic [2:0] s[$];
    n = raw_q.size() - 1;
    exp_q.delete();
    for (int e = 0; e <= n; e++) begin
      s.push_back((e >= 3) ? raw_q[e-2] : 3'b000);
      exp_q.push_back(5'b00001);
    end
    t = 1;
    while (t <= n) begin
      k = t;
      while (k <= n && s[k] != 3'b000) k++;
      if (k > n) break;
      idle_at = k + LOCK;
      if (idle_at > n) break;
      t = idle_at + 1;
      j = -1;
      for (int x = t; (x + DEB - 1 <= n) && (j < 0); x++) begin
        ok = (s[x] != 3'b000);
        for (int y = 1; y < DEB; y++) if (s[x+y] != s[x]) ok = 1'b0;
        if (ok) j = x;
      end
      last = (j < 0) ? n : j - 1;
      for (int e = idle_at; e <= last; e++)
        if (e == idle_at || s[e] == 3'b000) exp_q[e][0] = 1'b0;
      if (j < 0) break;
      q = j + DEB - 1;
      if (one_hot(s[j]) && acc_q[q]) exp_q[q][4:2] = s[j];
      else                           exp_q[q][1]   = 1'b1;
      t = q + 1;
    end
  endtask

  task automatic drive();
    obs_q.delete();
    @(negedge clk);
    rst = 1'b1;
    {sq, sd, sn} = raw_q[0];
    accept_en = acc_q[0];
    @(posedge clk);
    #1 obs_q.push_back({coin_in, coin_reject, busy});
    for (int k = 1; k < raw_q.size(); k++) begin
      @(negedge clk);
      rst = 1'b0;
      {sq, sd, sn} = raw_q[k];
      accept_en = acc_q[k];
      @(posedge clk);
      #1 obs_q.push_back({coin_in, coin_reject, busy});
    end
  endtask

  function automatic int count_coin(input logic [2:0] code);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][4:2] == code) c++;
    return c;
  endfunction

  function automatic int count_rej();
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) c++;
    return c;
  endfunction

  task automatic test_reset();
    start(3'b000); seg(3'b000, 14, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL reset cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (obs_q[0] !== 5'b00001) begin
      n_err++; $display("FAIL reset_state: got %b want 00001", obs_q[0]);
    end
    n_cmp++;
    if ({obs_q[LOCK][0], obs_q[LOCK+1][0]} !== 2'b10) begin
      n_err++; $display("FAIL reset_to_idle: busy@%0d,%0d got %b want 10", LOCK, LOCK+1,
                        {obs_q[LOCK][0], obs_q[LOCK+1][0]});
    end
  endtask

  task automatic test_nickel();
    start(3'b000); seg(3'b000, 10, 1'b1); seg(3'b001, 10, 1'b1); seg(3'b000, 20, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL nickel cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    // Raw rises before edge 11, so edge DEB+2 of the coin is edge 16.
    n_cmp++;
    if (obs_q[16] !== 5'b00101) begin
      n_err++; $display("FAIL nickel_latency: got %b want 00101", obs_q[16]);
    end
    n_cmp++;
    if (count_coin(3'b001) != 1 || count_rej() != 0 || obs_q[$][0] !== 1'b0) begin
      n_err++; $display("FAIL nickel_count: coins %0d rejects %0d final busy %b, want 1 0 0",
                        count_coin(3'b001), count_rej(), obs_q[$][0]);
    end
  endtask

  task automatic test_short_dime();
    start(3'b000); seg(3'b000, 10, 1'b1); seg(3'b010, 3, 1'b1); seg(3'b000, 20, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL short_dime cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (count_coin(3'b010) != 0 || count_rej() != 0 || obs_q[14][0] !== 1'b1 || obs_q[$][0] !== 1'b0) begin
      n_err++; $display("FAIL short_dime_sum: coins %0d rejects %0d busy@14 %b final busy %b, want 0 0 1 0",
                        count_coin(3'b010), count_rej(), obs_q[14][0], obs_q[$][0]);
    end
  endtask

  task automatic test_reject();
    start(3'b000); seg(3'b000, 10, 1'b1); seg(3'b101, 10, 1'b1); seg(3'b000, 20, 1'b1);
    seg(3'b100, 10, 1'b0); seg(3'b000, 20, 1'b0);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL reject cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (obs_q[16] !== 5'b00011 || count_rej() != 2 || count_coin(3'b100) != 0) begin
      n_err++; $display("FAIL reject_sum: @16 %b rejects %0d quarters %0d, want 00011 2 0",
                        obs_q[16], count_rej(), count_coin(3'b100));
    end
  endtask

  task automatic test_back_to_back();
    start(3'b000); seg(3'b000, 10, 1'b1); seg(3'b100, 40, 1'b1); seg(3'b000, 3, 1'b1);
    seg(3'b100, 20, 1'b1); seg(3'b000, 20, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    // Release seen at edge 53, IDLE after edge 61, second quarter qualifies at 65.
    n_cmp++;
    if (obs_q[16] !== 5'b10001 || obs_q[65] !== 5'b10001 || count_coin(3'b100) != 2) begin
      n_err++; $display("FAIL back_to_back_sum: @16 %b @65 %b quarters %0d, want 10001 10001 2",
                        obs_q[16], obs_q[65], count_coin(3'b100));
    end
  endtask

  task automatic test_bounce();
    start(3'b000); seg(3'b000, 10, 1'b1);
    repeat (3) begin seg(3'b001, 1, 1'b1); seg(3'b000, 1, 1'b1); end
    seg(3'b001, 10, 1'b1); seg(3'b000, 20, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL bounce cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (obs_q[22] !== 5'b00101 || count_coin(3'b001) != 1 || count_rej() != 0) begin
      n_err++; $display("FAIL bounce_sum: @22 %b nickels %0d rejects %0d, want 00101 1 0",
                        obs_q[22], count_coin(3'b001), count_rej());
    end
  endtask

  task automatic test_reset_mid_qualify();
    // Dime is captured at edge 15; edge 18 would qualify, but reset lands there.
    start(3'b000); seg(3'b000, 12, 1'b1); seg(3'b010, 5, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL mid_qualify_pre cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    start(3'b010); seg(3'b010, 10, 1'b1); seg(3'b000, 25, 1'b1);
    build_model(); drive();
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL mid_qualify_post cyc %0d: {coin,rej,busy} got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (obs_q[0] !== 5'b00001 || count_coin(3'b010) != 0 || count_rej() != 0 || obs_q[$][0] !== 1'b0) begin
      n_err++; $display("FAIL mid_qualify_sum: reset cyc %b dimes %0d rejects %0d final busy %b, want 00001 0 0 0",
                        obs_q[0], count_coin(3'b010), count_rej(), obs_q[$][0]);
    end
  endtask

  task automatic test_random();
    int         r;
    logic [2:0] v;
    for (int it = 0; it < 6; it++) begin
      start(3'($urandom_range(0, 7)));
      while (raw_q.size() < 200) begin
        r = $urandom_range(0, 9);
        if (r < 3)      v = 3'b000;
        else if (r < 8) v = 3'b001 << (r % 3);
        else            v = 3'($urandom_range(3, 7));
        seg(v, $urandom_range(1, 14), $urandom_range(0, 4) != 0);
      end
      build_model(); drive();
      foreach (obs_q[k]) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL random%0d cyc %0d: {coin,rej,busy} got %b want %b", it, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nickel();
    test_short_dime();
    test_reject();
    test_back_to_back();
    test_bounce();
    test_reset_mid_qualify();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor feeding the snack vending FSM. It synchronises and debounces three raw coin sensors (nickel, dime, quarter) and delivers exactly one single-cycle one-hot `coin_in` pulse per validated coin, in the 3-bit encoding the vending FSM consumes. Malformed or unaccepted insertions produce a reject pulse instead. A post-coin release/lockout window prevents a single slow coin from being counted twice.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required to qualify a coin; legal range ≥ 2.
- `LOCKOUT_CYCLES`, default 8: idle cycles enforced after all sensors release; legal range ≥ 1.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sensor_nickel`  in  1  raw asynchronous nickel-slot sensor, high = coin present.
- `sensor_dime`  in  1  raw asynchronous dime-slot sensor.
- `sensor_quarter`  in  1  raw asynchronous quarter-slot sensor.
- `accept_en`  in  1  downstream ready to take credit; sampled only on the qualifying cycle.
- `coin_in`  out  3  one-cycle one-hot pulse, registered: `001` nickel, `010` dime, `100` quarter; `000` otherwise.
- `coin_reject`  out  1  one-cycle pulse; qualified insertion not forwarded (multi-hot pattern, or `accept_en` low).
- `busy`  out  1  high in every state except IDLE.

## Operation
- Raw pattern `{quarter, dime, nickel}` passes through a 2-flop synchroniser, giving `s[2:0]`.
- All further logic uses only `s`.
- States:
  - **IDLE**: if `s != 0`: capture `pat <= s`, `cnt <= 1`, go to QUALIFY.
  - **QUALIFY**:
    - `s == 0`: glitch; go to IDLE, no output.
    - `s != 0 && s != pat`: recapture `pat <= s`, `cnt <= 1`, stay.
    - `s == pat && cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
    - `s == pat && cnt == DEBOUNCE_CYCLES-1`: qualified.
      - If `pat` is one-hot and `accept_en` = 1: `coin_in <= pat`.
      - Otherwise: `coin_reject <= 1`.
      - Go to RELEASE.
  - **RELEASE**: wait for `s == 0`. Then `cnt <= 0` and go to LOCKOUT. Sensor changes while in RELEASE never produce output.
  - **LOCKOUT**: `cnt` increments each cycle. At `cnt == LOCKOUT_CYCLES-1`, go to IDLE. A sensor going high during LOCKOUT is ignored for the remainder of LOCKOUT and is picked up by IDLE afterwards if still present.
- At most one of `coin_in != 0` and `coin_reject` is asserted in any cycle. Each is high for exactly one cycle per qualified insertion.
- Counter width: `$clog2(max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)) + 1`. The counter never wraps; it is reset on every state entry that uses it.
- Reset:
  - Synchronous `rst` clears the synchroniser flops, `pat`, and `cnt`, and forces state RELEASE.
  - All outputs are 0 in the cycle after the reset edge, except `busy`, which is 1.
  - A coin held across reset is therefore never credited. With sensors low, the block reaches IDLE `LOCKOUT_CYCLES + 1` cycles after reset deasserts.
  - Reset in any state, including the cycle a pulse would issue, suppresses that pulse.

## Timing
- Edge 1 is the first rising edge that samples a raw sensor high.
- `s` is high after edge 2; IDLE samples it at edge 3.
- With the sensor stable, `coin_in`/`coin_reject` is high in the cycle after edge `DEBOUNCE_CYCLES + 2` (edge 6 for the default), i.e. the pulse becomes visible after edge 6.
- Minimum raw high time to qualify: `DEBOUNCE_CYCLES` cycles. Any shorter pulse is dropped.
- Back-to-back coins: the next coin cannot qualify earlier than `2 + 1 + LOCKOUT_CYCLES + DEBOUNCE_CYCLES` cycles after the previous sensor release.
- `accept_en` has zero-cycle latency; only its value at the qualifying edge matters.

## Structure
- Shared package `vend_pkg`:
  - Coin code constants `COIN_NICKEL = 3'b001`, `COIN_DIME = 3'b010`, `COIN_QUARTER = 3'b100`, `COIN_NONE = 3'b000` (shared with the vending FSM).
  - State enum `acc_state_t` {IDLE, QUALIFY, RELEASE, LOCKOUT}.
- One sub-module: `coin_sync`, a parameterised-width 2-flop synchroniser with synchronous reset, instantiated once at width 3.
- FSM, counter, and output registers live in `coin_acceptor`.

## Test plan
- Default parameters, `accept_en` = 1, nickel raw high for 10 cycles then low: exactly one `coin_in = 001` pulse, visible after edge 6. `coin_reject` stays 0. `busy` returns to 0 after release plus sync plus lockout.
- Dime raw high for 3 cycles (shorter than `DEBOUNCE_CYCLES`): no `coin_in`, no `coin_reject`. `busy` pulses and the block returns to IDLE.
- Nickel and quarter high simultaneously for 10 cycles: a single `coin_reject` pulse and `coin_in` stays 000. A quarter with `accept_en` = 0 also gives a single `coin_reject` pulse.
- Quarter held high 40 cycles: exactly one `coin_in = 100`. A second quarter inserted 3 cycles after release (inside LOCKOUT) and held 20 cycles: credited once, after LOCKOUT ends.
- Sensor bouncing 1-0-1-0 every cycle for 6 cycles, then stable high: exactly one pulse, counted from the start of the stable period.
- `rst` asserted mid-QUALIFY with dime held through reset and 10 cycles after: no pulse. Outputs are 0 and `busy` is 1 the cycle after reset. After the dime releases, the block reaches IDLE.
